// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//   Fetch-stage controller sitting directly behind the PC register. It issues
//   one sram-like instruction-memory request at a time and buffers the returned
//   word for decode. It advances the PC register once per instruction that
//   decode accepts. Misaligned fetch addresses raise AdEL instead of going to
//   memory. After a flush, any response that is still in flight is dropped.
//
//   Ports
//     clk, resetn                 clock / asynchronous active-low reset
//     pc_f          in   [31:0]   current fetch address from the PC register
//     flush         in            exception/ERET flush (highest priority)
//     stall_d       in            decode cannot accept this cycle
//     pc_en         out           advance the PC register
//     inst_req      out           memory request valid
//     inst_addr     out  [31:0]   physical fetch address (pc_f & PHYS_MASK)
//     inst_addr_ok  in            request accepted this cycle
//     inst_data_ok  in            read data returned this cycle
//     inst_rdata    in   [31:0]   read data
//     instr_f       out  [31:0]   fetched instruction (0 on AdEL)
//     pc_out_f      out  [31:0]   virtual PC of instr_f
//     instr_valid   out           instr_f / pc_out_f / adel_f valid
//     adel_f        out           misaligned fetch for pc_out_f
//     fetch_stall   out           fetch not delivering (state != VALID)
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
   parameter logic [31:0] PHYS_MASK   = 32'h1FFF_FFFF,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] pc_f,
   input  logic        flush,
   input  logic        stall_d,
   output logic        pc_en,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] instr_f,
   output logic [31:0] pc_out_f,
   output logic        instr_valid,
   output logic        adel_f,
   output logic        fetch_stall
);

   typedef enum logic [1:0] {
      S_REQ       = 2'd0,
      S_WAIT_DATA = 2'd1,
      S_VALID     = 2'd2,
      S_DISCARD   = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic        r_adel;

   logic w_misaligned;
   logic w_in_req;
   logic w_in_valid;

   assign w_misaligned = ALIGN_CHECK && (pc_f[1:0] != 2'b00);
   assign w_in_req     = (r_state == S_REQ);
   assign w_in_valid   = (r_state == S_VALID);

   // The handshake outputs must react to flush/stall_d and to the PC register
   // in the same cycle, so they are decoded from the state rather than
   // registered. Gating with resetn keeps them at 0 while reset is held even
   // though the state already reads REQ.
   assign inst_req    = resetn & w_in_req & ~w_misaligned;
   assign inst_addr   = pc_f & PHYS_MASK;
   assign instr_valid = resetn & w_in_valid & ~flush;
   assign pc_en       = resetn & w_in_valid & ~stall_d & ~flush;
   assign fetch_stall = ~w_in_valid;

   assign instr_f  = r_instr;
   assign pc_out_f = r_pc;
   assign adel_f   = r_adel;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here sees the pre-edge value of every other register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_REQ;
         r_instr <= '0;
         r_pc    <= '0;
         r_adel  <= 1'b0;
      end else begin
         case (r_state)
            S_REQ: begin
               if (flush) begin
                  // A request the memory accepted in the flush cycle is
                  // committed; its response must be swallowed later.
                  if (!w_misaligned && inst_addr_ok) r_state <= S_DISCARD;
               end else if (w_misaligned) begin
                  r_state <= S_VALID;
                  r_instr <= '0;
                  r_adel  <= 1'b1;
                  r_pc    <= pc_f;
               end else if (inst_addr_ok) begin
                  r_state <= S_WAIT_DATA;
                  r_pc    <= pc_f;
               end
            end
            S_WAIT_DATA: begin
               if (inst_data_ok) begin
                  if (flush) begin
                     r_state <= S_REQ;
                  end else begin
                     r_state <= S_VALID;
                     r_instr <= inst_rdata;
                     r_adel  <= 1'b0;
                  end
               end else if (flush) begin
                  r_state <= S_DISCARD;
               end
            end
            S_VALID: begin
               if (flush || !stall_d) r_state <= S_REQ;
            end
            S_DISCARD: begin
               // The outstanding response is consumed here whether or not a
               // new flush arrives with it; waiting on would never end.
               if (inst_data_ok) r_state <= S_REQ;
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//   Bench for inst_fetch_ctrl. It models a PC register and an instruction
//   memory with one outstanding request and a random response delay. The
//   reference model is architectural. Each new PC value queues the result that
//   decode must eventually see for it: the PC, the memory word at the PC's
//   physical address, or AdEL. A flush replaces the pending expectation. A
//   monitor compares every valid instruction against the queue head.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

   localparam logic [31:0] MASK = 32'h1FFF_FFFF;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] pc_f;
   logic        flush;
   logic        stall_d;
   logic        pc_en;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic [31:0] instr_f;
   logic [31:0] pc_out_f;
   logic        instr_valid;
   logic        adel_f;
   logic        fetch_stall;

   inst_fetch_ctrl dut (
      .clk          (clk),
      .resetn       (resetn),
      .pc_f         (pc_f),
      .flush        (flush),
      .stall_d      (stall_d),
      .pc_en        (pc_en),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .instr_f      (instr_f),
      .pc_out_f     (pc_out_f),
      .instr_valid  (instr_valid),
      .adel_f       (adel_f),
      .fetch_stall  (fetch_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } exp_t;

   int n_checks = 0;
   int n_errors = 0;

   // environment / reference state
   exp_t        exp_q[$];
   logic [31:0] forced_pc_q[$];
   logic [31:0] pc_model;
   bit          in_reset;
   int          cyc = 0;
   int          last_acc_cyc = -1;
   int          req_hold = 0;
   int          accepts = 0;
   int          idle = 0;
   bit          mem_pend = 1'b0;
   int          mem_due = 0;
   logic [31:0] mem_addr;

   // stimulus knobs
   int addr_pct  = 100;
   int addr_wait = 0;
   int dly_min   = 1;
   int dly_max   = 1;
   int stall_pct = 0;
   int flush_pct = 0;
   bit flush_next      = 1'b0;
   bit flush_on_data   = 1'b0;
   bit flush_req_noack = 1'b0;
   bit ev_flush_req    = 1'b0;
   bit stale_deadbeef  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
   endfunction

   function automatic exp_t expect_for(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.adel  = (pc[1:0] != 2'b00);
      e.instr = e.adel ? 32'h0 : mem_word(pc & MASK);
      return e;
   endfunction

   function automatic logic [31:0] rand_target();
      logic [31:0] r;
      logic [31:0] t;
      r = $urandom;
      t = (r[28] ? 32'h9FC0_0000 : 32'hBFC0_0000) | {16'h0, r[15:2], 2'b00};
      if (r[31:29] == 3'b000) t[1:0] = {r[16], 1'b1};
      return t;
   endfunction

   // PC register model: a flush loads a new target, pc_en steps to pc+4;
   // forced_pc_q overrides the next value for directed scenarios.
   task automatic next_pc(input bit is_flush);
      if (forced_pc_q.size() > 0) pc_model = forced_pc_q.pop_front();
      else if (is_flush)          pc_model = rand_target();
      else                        pc_model = pc_model + 32'd4;
      if (is_flush) exp_q.delete();
      exp_q.push_back(expect_for(pc_model));
      req_hold = 0;
   endtask

   task automatic step();
      @(negedge clk);
      #4;
   endtask

   // Driver: inputs at the falling edge, memory handshake at +1, environment
   // state update at +3 (after the monitor has sampled at +2).
   always begin
      @(negedge clk);
      cyc++;
      pc_f         = pc_model;
      flush        = 1'b0;
      stall_d      = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
      if (!in_reset) begin
         stall_d = ($urandom_range(99) < stall_pct);
         if (mem_pend && cyc >= mem_due) begin
            inst_data_ok = 1'b1;
            inst_rdata   = stale_deadbeef ? 32'hDEAD_BEEF : mem_word(mem_addr);
            stale_deadbeef = 1'b0;
         end
      end
      #1;
      if (!in_reset) begin
         flush = ($urandom_range(99) < flush_pct);
         if (flush_next) begin
            flush = 1'b1;
            flush_next = 1'b0;
         end
         if (flush_on_data && inst_data_ok) begin
            flush = 1'b1;
            flush_on_data = 1'b0;
         end
         if (inst_req) begin
            req_hold++;
            if (flush_req_noack) begin
               flush = 1'b1;
               flush_req_noack = 1'b0;
               ev_flush_req = 1'b1;
            end else if (req_hold > addr_wait && $urandom_range(99) < addr_pct) begin
               inst_addr_ok = 1'b1;
            end
         end else begin
            req_hold = 0;
         end
      end
      #2;
      if (!in_reset) begin
         if (inst_req) check("single_outstanding", {31'h0, mem_pend}, 32'h0);
         if (inst_data_ok) mem_pend = 1'b0;
         if (inst_req && inst_addr_ok) begin
            mem_pend     = 1'b1;
            mem_addr     = inst_addr;
            mem_due      = cyc + $urandom_range(dly_max, dly_min);
            last_acc_cyc = cyc;
            req_hold     = 0;
         end
         if (flush)      next_pc(1'b1);
         else if (pc_en) next_pc(1'b0);
      end
   end

   // Monitor / scoreboard
   always begin
      @(negedge clk);
      #2;
      if (!in_reset) begin
         if (flush) begin
            check("valid_during_flush", {31'h0, instr_valid}, 32'h0);
            check("pc_en_during_flush", {31'h0, pc_en}, 32'h0);
         end else if (instr_valid) begin
            check("fetch_stall_when_valid", {31'h0, fetch_stall}, 32'h0);
            check("pc_en_vs_stall", {31'h0, pc_en}, {31'h0, ~stall_d});
         end else begin
            check("fetch_stall_when_idle", {31'h0, fetch_stall}, 32'h1);
            check("pc_en_when_idle", {31'h0, pc_en}, 32'h0);
         end
         if (instr_valid) begin
            check("exp_available", exp_q.size(), 32'd1);
            if (exp_q.size() > 0) begin
               check("pc_out_f", pc_out_f, exp_q[0].pc);
               check("instr_f", instr_f, exp_q[0].instr);
               check("adel_f", {31'h0, adel_f}, {31'h0, exp_q[0].adel});
               if (!stall_d) begin
                  void'(exp_q.pop_front());
                  accepts++;
                  idle = 0;
               end
            end
         end
         if (inst_req) begin
            check("inst_addr", inst_addr, pc_model & MASK);
            check("req_aligned", {30'h0, pc_model[1:0]}, 32'h0);
         end
         idle++;
         if (idle > 400) begin
            check("watchdog_no_progress", idle, 0);
            idle = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int a0;
      int n_req;
      int acc0;
      bit saw;
      exp_t e;

      in_reset = 1'b1;
      resetn   = 1'b0;
      pc_model = 32'hBFC0_0000;
      repeat (2) step();

      // reset state
      check("rst_inst_req", {31'h0, inst_req}, 32'h0);
      check("rst_pc_en", {31'h0, pc_en}, 32'h0);
      check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_instr_f", instr_f, 32'h0);
      check("rst_pc_out_f", pc_out_f, 32'h0);
      check("rst_adel_f", {31'h0, adel_f}, 32'h0);
      check("rst_fetch_stall", {31'h0, fetch_stall}, 32'h1);

      // 1: first fetch after reset, zero-wait memory
      exp_q.push_back(expect_for(pc_model));
      in_reset = 1'b0;
      resetn   = 1'b1;
      step();
      check("t1_req", {31'h0, inst_req}, 32'h1);
      check("t1_addr", inst_addr, 32'h1FC0_0000);
      step();
      check("t1_c1_not_valid", {31'h0, instr_valid}, 32'h0);
      step();
      check("t1_c2_valid", {31'h0, instr_valid}, 32'h1);
      check("t1_c2_instr", instr_f, mem_word(32'h1FC0_0000));
      check("t1_c2_pc_en", {31'h0, pc_en}, 32'h1);
      step();
      check("t1_c3_pc_en_pulse", {31'h0, pc_en}, 32'h0);
      check("t1_c3_req", {31'h0, inst_req}, 32'h1);
      check("t1_c3_addr", inst_addr, 32'h1FC0_0004);
      acc0 = accepts;
      repeat (30) step();
      check("t1_throughput_30cyc", accepts - acc0, 32'd10);

      // 2: decode stalls for three cycles
      stall_pct = 100;
      for (int n = 0; n < 10 && !instr_valid; n++) step();
      check("t2_valid_seen", {31'h0, instr_valid}, 32'h1);
      e = expect_for(pc_model);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) step();
         check("t2_stall_valid", {31'h0, instr_valid}, 32'h1);
         check("t2_stall_pc_en", {31'h0, pc_en}, 32'h0);
         check("t2_stall_pc_out", pc_out_f, e.pc);
         check("t2_stall_instr", instr_f, e.instr);
      end
      stall_pct = 0;
      step();
      check("t2_release_pc_en", {31'h0, pc_en}, 32'h1);
      step();
      check("t2_back_to_req", {31'h0, inst_req}, 32'h1);

      // 3: misaligned fetch
      forced_pc_q.push_back(32'hBFC0_0002);
      forced_pc_q.push_back(32'hBFC0_0380);
      for (int n = 0; n < 20 && pc_model != 32'hBFC0_0002; n++) step();
      check("t3_pc_reached", pc_model, 32'hBFC0_0002);
      saw = 1'b0;
      for (int n = 0; n < 5 && !saw; n++) begin
         step();
         check("t3_no_req", {31'h0, inst_req}, 32'h0);
         if (instr_valid) begin
            saw = 1'b1;
            check("t3_adel", {31'h0, adel_f}, 32'h1);
            check("t3_instr_zero", instr_f, 32'h0);
            check("t3_pc_out", pc_out_f, 32'hBFC0_0002);
         end
      end
      check("t3_adel_delivered", {31'h0, saw}, 32'h1);

      // 4: flush while waiting for data; the late response is stale
      dly_min = 3;
      dly_max = 3;
      for (int n = 0; n < 20 && last_acc_cyc != cyc; n++) step();
      check("t4_accept_seen", last_acc_cyc, cyc);
      stale_deadbeef = 1'b1;
      forced_pc_q.push_back(32'hBFC0_0380);
      flush_next = 1'b1;
      dly_min = 1;
      dly_max = 1;
      saw = 1'b0;
      for (int n = 0; n < 20 && !saw; n++) begin
         step();
         if (instr_valid) begin
            saw = 1'b1;
            check("t4_pc_out", pc_out_f, 32'hBFC0_0380);
            check("t4_not_stale", {31'h0, instr_f == 32'hDEAD_BEEF}, 32'h0);
         end
      end
      check("t4_new_fetch_delivered", {31'h0, saw}, 32'h1);

      // 5: flush with data_ok, then flush in REQ without addr_ok
      dly_min = 2;
      dly_max = 2;
      forced_pc_q.push_back(32'hBFC0_1000);
      flush_on_data = 1'b1;
      for (int n = 0; n < 20 && flush_on_data; n++) step();
      check("t5_flush_data_done", {31'h0, flush_on_data}, 32'h0);
      check("t5a_no_valid", {31'h0, instr_valid}, 32'h0);
      check("t5a_no_pc_en", {31'h0, pc_en}, 32'h0);
      forced_pc_q.push_back(32'hBFC0_2000);
      flush_req_noack = 1'b1;
      for (int n = 0; n < 20 && !ev_flush_req; n++) step();
      check("t5_flush_req_done", {31'h0, ev_flush_req}, 32'h1);
      check("t5b_no_valid", {31'h0, instr_valid}, 32'h0);
      check("t5b_no_pc_en", {31'h0, pc_en}, 32'h0);
      addr_wait = 4;
      dly_min   = 8;
      dly_max   = 8;
      step();
      check("t5_rereq", {31'h0, inst_req}, 32'h1);
      check("t5_rereq_addr", inst_addr, 32'h1FC0_2000);

      // 6: slow addr_ok, then reset in the middle of WAIT_DATA
      a0 = inst_addr;
      n_req = 1;
      for (int n = 0; n < 10 && last_acc_cyc != cyc; n++) begin
         step();
         if (inst_req) begin
            n_req++;
            check("t6_addr_stable", inst_addr, a0);
         end
      end
      check("t6_req_cycles", n_req, 32'd5);
      step();
      in_reset = 1'b1;
      resetn   = 1'b0;
      #2;
      check("t6_rst_inst_req", {31'h0, inst_req}, 32'h0);
      check("t6_rst_pc_en", {31'h0, pc_en}, 32'h0);
      check("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
      check("t6_rst_instr_f", instr_f, 32'h0);
      check("t6_rst_pc_out_f", pc_out_f, 32'h0);
      check("t6_rst_adel", {31'h0, adel_f}, 32'h0);
      mem_pend = 1'b0;
      exp_q.delete();
      forced_pc_q.delete();
      pc_model  = 32'hBFC0_0000;
      req_hold  = 0;
      addr_wait = 0;
      dly_min   = 1;
      dly_max   = 1;
      stale_deadbeef = 1'b0;
      repeat (2) step();
      check("t6_held_inst_req", {31'h0, inst_req}, 32'h0);
      exp_q.push_back(expect_for(pc_model));
      in_reset = 1'b0;
      resetn   = 1'b1;
      step();
      check("t6_fresh_req", {31'h0, inst_req}, 32'h1);
      check("t6_fresh_addr", inst_addr, 32'h1FC0_0000);

      // random traffic
      addr_pct  = 60;
      dly_min   = 1;
      dly_max   = 4;
      stall_pct = 30;
      flush_pct = 5;
      repeat (3000) step();
      flush_pct = 0;
      stall_pct = 0;
      acc0 = accepts;
      repeat (60) step();
      check("drain_progress", {31'h0, accepts > acc0}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
